// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot bullet engine for one tank.
// Handles fire edge-detect, launch cooldown, per-slot motion, and clearing on hits and walls.
// Updates once per frame_clk.
// Optional feature: define BULLET_BOUNCE_EN so bullets reflect off walls, up to MAX_BOUNCE
// times, instead of dying at the first wall.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 5,
  parameter int SIZE        = 2,
  parameter int COOLDOWN    = 8,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int MAX_BOUNCE  = 2
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      gaming_on,
  input  logic                      fire_req,
  input  logic                      dir_valid,
  input  logic [1:0]                dir,
  input  logic [9:0]                TankX,
  input  logic [9:0]                TankY,
  input  logic [NUM_BULLETS-1:0]    hit,
  output logic [NUM_BULLETS-1:0]    bullet_on,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [9:0]                BulletS,
  output logic                      shot_fired
);

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [10:0] SPD  = 11'(SPEED);
  localparam logic signed [10:0] SZ   = 11'(SIZE);
  localparam logic signed [10:0] X_HI = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX - SIZE);

  dir_t                    heading;
  logic                    fire_prev;
  logic [CW-1:0]           cooldown;
  logic [9:0]              pos_x [NUM_BULLETS];
  logic [9:0]              pos_y [NUM_BULLETS];
  logic signed [10:0]      mot_x [NUM_BULLETS];
  logic signed [10:0]      mot_y [NUM_BULLETS];
`ifdef BULLET_BOUNCE_EN
  logic [1:0]              bounce [NUM_BULLETS];
`endif

  logic [NUM_BULLETS-1:0]  free_slots;
  logic [NUM_BULLETS-1:0]  launch_sel;
  logic                    fire_edge;
  logic                    launch;
  logic signed [10:0]      launch_mx;
  logic signed [10:0]      launch_my;
  logic signed [10:0]      nx [NUM_BULLETS];
  logic signed [10:0]      ny [NUM_BULLETS];
  logic [NUM_BULLETS-1:0]  wall_x;
  logic [NUM_BULLETS-1:0]  wall_y;

  // Pick the lowest free slot (isolate the lowest set bit) and qualify the launch.
  always_comb begin
    free_slots = ~bullet_on;
    launch_sel = free_slots & (~free_slots + NUM_BULLETS'(1));
    fire_edge  = fire_req & ~fire_prev;
    launch     = gaming_on & fire_edge & (cooldown == '0) & (|free_slots);
  end

  // Launch velocity follows the latched heading; screen Y grows downward.
  always_comb begin
    launch_mx = '0;
    launch_my = '0;
    case (heading)
      DIR_LEFT:  launch_mx = -SPD;
      DIR_RIGHT: launch_mx = SPD;
      DIR_DOWN:  launch_my = SPD;
      default:   launch_my = -SPD;
    endcase
  end

  // Candidate next position per slot, evaluated signed so a step past 0 does not wrap.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      nx[i]     = $signed({1'b0, pos_x[i]}) + mot_x[i];
      ny[i]     = $signed({1'b0, pos_y[i]}) + mot_y[i];
      wall_x[i] = (nx[i] <= SZ) || (nx[i] >= X_HI);
      wall_y[i] = (ny[i] <= SZ) || (ny[i] >= Y_HI);
    end
  end

  // Per-frame state update: heading, fire edge, cooldown, launch and motion of each slot.
  // NOTE: the small per-slot arrays are plain registers, so they are reset like any other flop.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      heading    <= DIR_UP;
      fire_prev  <= 1'b0;
      cooldown   <= '0;
      shot_fired <= 1'b0;
      bullet_on  <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        pos_x[i]  <= '0;
        pos_y[i]  <= '0;
        mot_x[i]  <= '0;
        mot_y[i]  <= '0;
`ifdef BULLET_BOUNCE_EN
        bounce[i] <= '0;
`endif
      end
    end else begin
      fire_prev  <= fire_req;
      shot_fired <= 1'b0;
      if (dir_valid) heading <= dir_t'(dir);
      if (gaming_on) begin
        if (launch) begin
          cooldown   <= CW'(COOLDOWN);
          shot_fired <= 1'b1;
        end else if (cooldown != '0) begin
          cooldown <= cooldown - CW'(1);
        end
        for (int i = 0; i < NUM_BULLETS; i++) begin
          if (bullet_on[i]) begin
            if (hit[i]) begin
              bullet_on[i] <= 1'b0;
              mot_x[i]     <= '0;
              mot_y[i]     <= '0;
            end else if (wall_x[i] || wall_y[i]) begin
`ifdef BULLET_BOUNCE_EN
              if (bounce[i] != 2'd0) begin
                if (wall_x[i]) mot_x[i] <= -mot_x[i];
                if (wall_y[i]) mot_y[i] <= -mot_y[i];
                bounce[i] <= bounce[i] - 2'd1;
              end else begin
                bullet_on[i] <= 1'b0;
                mot_x[i]     <= '0;
                mot_y[i]     <= '0;
              end
`else
              bullet_on[i] <= 1'b0;
              mot_x[i]     <= '0;
              mot_y[i]     <= '0;
`endif
            end else begin
              pos_x[i] <= nx[i][9:0];
              pos_y[i] <= ny[i][9:0];
            end
          end else if (launch && launch_sel[i]) begin
            bullet_on[i] <= 1'b1;
            pos_x[i]     <= TankX;
            pos_y[i]     <= TankY;
            mot_x[i]     <= launch_mx;
            mot_y[i]     <= launch_my;
`ifdef BULLET_BOUNCE_EN
            bounce[i]    <= 2'(MAX_BOUNCE);
`endif
          end
        end
      end
    end
  end

  // Pack slot positions onto the flat output buses.
  always_comb begin
    BulletX = '0;
    BulletY = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      BulletX[10*i +: 10] = pos_x[i];
      BulletY[10*i +: 10] = pos_y[i];
    end
    BulletS = 10'(SIZE);
  end

endmodule

// File: tb/tb_bullet_pool.sv
// tb_bullet_pool: directed checks of bullet_pool in its default configuration.
// Covers reset, fire edge-detect, cooldown, pool exhaustion and reuse, freeze, the wall
// clear, and asynchronous reset during flight.
module tb_bullet_pool;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        gaming_on;
  logic        fire_req;
  logic        dir_valid;
  logic [1:0]  dir;
  logic [9:0]  TankX;
  logic [9:0]  TankY;
  logic [3:0]  hit;
  logic [3:0]  bullet_on;
  logic [39:0] BulletX;
  logic [39:0] BulletY;
  logic [9:0]  BulletS;
  logic        shot_fired;

  int tests = 0;
  int fails = 0;
  int shots;

  bullet_pool dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .gaming_on (gaming_on),
    .fire_req  (fire_req),
    .dir_valid (dir_valid),
    .dir       (dir),
    .TankX     (TankX),
    .TankY     (TankY),
    .hit       (hit),
    .bullet_on (bullet_on),
    .BulletX   (BulletX),
    .BulletY   (BulletY),
    .BulletS   (BulletS),
    .shot_fired(shot_fired)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one frame and settle just after the active edge.
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  function automatic logic [9:0] bx(input int i);
    return BulletX[10*i +: 10];
  endfunction

  function automatic logic [9:0] by(input int i);
    return BulletY[10*i +: 10];
  endfunction

  initial begin
    Reset     = 1'b1;
    gaming_on = 1'b1;
    fire_req  = 1'b0;
    dir_valid = 1'b0;
    dir       = 2'd0;
    TankX     = 10'd100;
    TankY     = 10'd200;
    hit       = 4'b0000;
    #2;
    check("reset_on",    bullet_on, 4'b0000);
    check("reset_x",     BulletX, 40'd0);
    check("reset_y",     BulletY, 40'd0);
    check("reset_shot",  shot_fired, 1'b0);
    check("size_const",  BulletS, 10'd2);
    @(posedge frame_clk);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    // Held fire key: one launch upward from (100,200), then 5 px per frame.
    fire_req = 1'b1;
    shots = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (shot_fired) shots++;
      if (k == 0) begin
        check("launch_on", bullet_on, 4'b0001);
        check("launch_x0", bx(0), 10'd100);
        check("launch_y0", by(0), 10'd200);
      end
      if (k == 1) check("move1_y0", by(0), 10'd195);
      if (k == 2) check("move2_y0", by(0), 10'd190);
    end
    check("held_shots", shots, 1);
    check("held_on",    bullet_on, 4'b0001);
    check("held_y0",    by(0), 10'd105);

    // Hit clears slot 0 and holds its position.
    fire_req = 1'b0;
    hit      = 4'b0001;
    step();
    check("hit_on", bullet_on, 4'b0000);
    check("hit_y0", by(0), 10'd105);
    hit   = 4'b0000;
    TankX = 10'd320;
    TankY = 10'd470;

    // Cooldown: launch, then an edge three frames later is dropped.
    fire_req = 1'b1;
    step();
    check("cd_launch_on",   bullet_on, 4'b0001);
    check("cd_launch_shot", shot_fired, 1'b1);
    check("cd_launch_x0",   bx(0), 10'd320);
    check("cd_launch_y0",   by(0), 10'd470);
    fire_req = 1'b0;
    step();
    step();
    fire_req = 1'b1;
    step();
    check("cd_drop_on",   bullet_on, 4'b0001);
    check("cd_drop_shot", shot_fired, 1'b0);
    fire_req = 1'b0;
    repeat (5) step();
    fire_req = 1'b1;
    step();
    check("cd_ninth_on",   bullet_on, 4'b0011);
    check("cd_ninth_shot", shot_fired, 1'b1);
    check("cd_ninth_y1",   by(1), 10'd470);
    check("cd_ninth_y0",   by(0), 10'd425);

    // Fill the remaining slots.
    fire_req = 1'b0;
    repeat (8) step();
    fire_req = 1'b1;
    step();
    check("fill_slot2", bullet_on, 4'b0111);
    fire_req = 1'b0;
    repeat (8) step();
    fire_req = 1'b1;
    step();
    check("fill_slot3", bullet_on, 4'b1111);

    // Pool full: edge with cooldown expired is dropped.
    fire_req = 1'b0;
    repeat (8) step();
    fire_req = 1'b1;
    step();
    check("full_on",   bullet_on, 4'b1111);
    check("full_shot", shot_fired, 1'b0);
    check("full_y0",   by(0), 10'd290);

    // Free slot 2 by hit, then the next edge reuses it.
    fire_req = 1'b0;
    hit      = 4'b0100;
    step();
    check("free2_on", bullet_on, 4'b1011);
    hit   = 4'b0000;
    TankX = 10'd50;
    fire_req = 1'b1;
    step();
    check("reuse2_on",   bullet_on, 4'b1111);
    check("reuse2_shot", shot_fired, 1'b1);
    check("reuse2_x2",   bx(2), 10'd50);
    check("reuse2_y2",   by(2), 10'd470);

    // Freeze: positions hold while gaming_on is low.
    fire_req  = 1'b0;
    gaming_on = 1'b0;
    step();
    check("freeze_y0",   by(0), 10'd280);
    check("freeze_shot", shot_fired, 1'b0);
    check("freeze_on",   bullet_on, 4'b1111);
    gaming_on = 1'b1;

    // Asynchronous reset in flight, away from any clock edge.
    #3;
    Reset = 1'b1;
    #1;
    check("async_on", bullet_on, 4'b0000);
    check("async_x",  BulletX, 40'd0);
    check("async_y",  BulletY, 40'd0);
    step();
    Reset = 1'b0;

    // Rightward bullet from X=630 dies at the right wall.
    TankX     = 10'd630;
    TankY     = 10'd100;
    dir_valid = 1'b1;
    dir       = 2'd1;
    step();
    dir_valid = 1'b0;
    fire_req  = 1'b1;
    step();
    check("right_launch_on", bullet_on, 4'b0001);
    check("right_launch_x0", bx(0), 10'd630);
    fire_req = 1'b0;
    step();
    check("right_move_x0", bx(0), 10'd635);
    check("right_move_y0", by(0), 10'd100);
    step();
    check("right_wall_on", bullet_on, 4'b0000);
    check("right_wall_x0", bx(0), 10'd635);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
